// File: rtl/cache_bitrev_reader_if.sv
// Bundles the frame-control, cache read port and output stream signals of cache_bitrev_reader.
// master = the reader itself, slave = its environment (cache + consumer + controller).
interface cache_bitrev_reader_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
);
  logic              start;
  logic [3:0]        log2n;
  logic              bitrev;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_read_adr;
  logic [DATA_W-1:0] mem_read_data;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_index;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (
    input  start, log2n, bitrev, mem_read_data, m_ready,
    output busy, done, mem_read_adr, m_data, m_index, m_valid, m_last
  );

  modport slave (
    output start, log2n, bitrev, mem_read_data, m_ready,
    input  busy, done, mem_read_adr, m_data, m_index, m_valid, m_last
  );
endinterface

// File: rtl/cache_bitrev_reader.sv
// Streams one 2^log2n-word frame out of the sample cache in linear or bit-reversed order,
// absorbing the cache's one-cycle read latency through a credit-checked 2-entry output FIFO.
module cache_bitrev_reader #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  cache_bitrev_reader_if.master   io_bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] ADDR_W_L = 4'(ADDR_W);

  logic [1:0]        r_state;
  logic [1:0]        w_state_d;
  logic [3:0]        r_log2n;
  logic              r_bitrev;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_tag;
  logic              r_inflight;

  logic [DATA_W-1:0] r_fifo_data [2];
  logic [ADDR_W-1:0] r_fifo_idx  [2];
  logic [1:0]        r_fifo_last;
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;

  logic [ADDR_W-1:0] w_last_ord;
  logic [ADDR_W-1:0] w_idx_full_rev;
  logic [ADDR_W-1:0] w_idx_rev;
  logic [3:0]        w_log2n_clamp;
  logic              w_start_ok;
  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic              w_last_issue;

  assign w_last_ord = ~({ADDR_W{1'b1}} << r_log2n);

  always_comb begin
    w_idx_full_rev = '0;
    for (int i = 0; i < int'(ADDR_W); i++) begin
      w_idx_full_rev[i] = r_idx[ADDR_W-1-i];
    end
  end

  // Full-width reversal then shift down: idx < N, so only the low log2n bits survive, reversed.
  assign w_idx_rev = w_idx_full_rev >> (ADDR_W_L - r_log2n);

  assign w_log2n_clamp = (io_bus.log2n == 4'd0 || io_bus.log2n > ADDR_W_L) ? ADDR_W_L
                                                                           : io_bus.log2n;

  assign w_start_ok   = (r_state == S_IDLE) && io_bus.start;
  assign w_pop        = io_bus.m_valid && io_bus.m_ready;
  assign w_push       = r_inflight;
  // Credit check: buffered + in-flight, net of this edge's pop, must leave room for one more.
  assign w_issue      = (r_state == S_RUN) &&
                        (({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));
  assign w_last_issue = w_issue && (r_idx == w_last_ord);

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      S_IDLE:  if (io_bus.start) w_state_d = S_RUN;
      S_RUN:   if (w_last_issue) w_state_d = S_DRAIN;
      S_DRAIN: begin
        // Leave as the final beat is popped so done lands in the very next cycle.
        if (!r_inflight && (r_count == 2'd0 || (r_count == 2'd1 && w_pop))) begin
          w_state_d = S_DONE;
        end
      end
      S_DONE:  w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_log2n     <= ADDR_W_L;
      r_bitrev    <= 1'b0;
      r_idx       <= '0;
      r_tag       <= '0;
      r_inflight  <= 1'b0;
      r_fifo_last <= 2'b00;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_count     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_idx[i]  <= '0;
      end
    end else begin
      r_state <= w_state_d;
      if (w_start_ok) begin
        r_log2n  <= w_log2n_clamp;
        r_bitrev <= io_bus.bitrev;
        r_idx    <= '0;
      end
      if (w_issue) begin
        r_idx <= r_idx + 1'b1;
        r_tag <= r_idx;
      end
      r_inflight <= w_issue;
      if (w_push) begin
        r_fifo_data[r_wptr] <= io_bus.mem_read_data;
        r_fifo_idx[r_wptr]  <= r_tag;
        r_fifo_last[r_wptr] <= (r_tag == w_last_ord);
        r_wptr              <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign io_bus.mem_read_adr = r_bitrev ? w_idx_rev : r_idx;
  assign io_bus.busy         = (r_state != S_IDLE);
  assign io_bus.done         = (r_state == S_DONE);
  assign io_bus.m_valid      = (r_count != 2'd0);
  assign io_bus.m_data       = r_fifo_data[r_rptr];
  assign io_bus.m_index      = r_fifo_idx[r_rptr];
  assign io_bus.m_last       = r_fifo_last[r_rptr];

endmodule

// File: tb/tb_cache_bitrev_reader.sv
// Directed bench for cache_bitrev_reader: cache model returns 0x1000+addr one cycle after the
// address; frames are checked beat by beat against hand-derived order.
module tb_cache_bitrev_reader;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  cache_bitrev_reader_if #(.ADDR_W(12), .DATA_W(16)) bus ();

  cache_bitrev_reader #(.ADDR_W(12), .DATA_W(16)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read cache model, MEM[i] = 0x1000 + i.
  always @(posedge clk) bus.mem_read_data <= 16'h1000 + 16'(bus.mem_read_adr);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_data(input int k, input int l2, input bit br);
    int a;
    a = 0;
    if (br) begin
      for (int i = 0; i < l2; i++) if (k[i]) a = a | (1 << (l2 - 1 - i));
    end else begin
      a = k;
    end
    return 16'(32'h1000 + a);
  endfunction

  task automatic do_start(input int l2, input bit br);
    bus.start  = 1'b1;
    bus.log2n  = 4'(l2);
    bus.bitrev = br;
    tick;
    bus.start  = 1'b0;
    bus.log2n  = 4'd5;
    bus.bitrev = ~br;
  endtask

  // mode 0: ready always high (also checks no bubbles); mode 1: random ready.
  // ms >= 0 pulses start while beat ms is at the head; stop_at >= 0 returns before beat stop_at.
  task automatic collect(input int l2, input bit br, input int mode, input int ms,
                         input int stop_at);
    int          n;
    int          k;
    int          cyc;
    bit          stalled;
    bit          seen;
    bit          ms_done;
    logic [15:0] sd;
    logic [11:0] si;
    n = 1 << l2;
    k = 0;
    cyc = 0;
    stalled = 1'b0;
    seen = 1'b0;
    ms_done = 1'b0;
    sd = '0;
    si = '0;
    while (k < n && cyc < 20000 && !(stop_at >= 0 && k == stop_at)) begin
      bus.m_ready = (mode == 0) ? 1'b1 : ($urandom_range(1, 0) != 0);
      if (ms >= 0 && k == ms && !ms_done) begin
        bus.start = 1'b1;
        ms_done = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (stalled) begin
        check("stall_data", bus.m_data, sd);
        check("stall_index", bus.m_index, si);
      end
      if (mode == 0 && seen) check("no_bubble", bus.m_valid, 1);
      stalled = 1'b0;
      if (bus.m_valid) begin
        seen = 1'b1;
        if (bus.m_ready) begin
          check("beat_data", bus.m_data, exp_data(k, l2, br));
          check("beat_index", bus.m_index, k);
          check("beat_last", bus.m_last, (k == n - 1));
          k++;
        end else begin
          stalled = 1'b1;
          sd = bus.m_data;
          si = bus.m_index;
        end
      end
      tick;
      cyc++;
    end
    bus.start = 1'b0;
    if (stop_at < 0) begin
      check("beat_count", k, n);
      check("done_pulse", bus.done, 1);
      check("busy_in_done", bus.busy, 1);
      check("no_extra_beat", bus.m_valid, 0);
      bus.start = 1'b1;   // must be ignored in DONE
      tick;
      bus.start = 1'b0;
      check("done_falls", bus.done, 0);
      check("idle_after_done", bus.busy, 0);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.log2n  = 4'd0;
    bus.bitrev = 1'b0;
    bus.m_ready = 1'b0;
    tick;
    tick;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_valid", bus.m_valid, 0);
    check("rst_adr", bus.mem_read_adr, 0);
    rst = 1'b0;
    tick;

    // Linear N=8 with first-valid latency.
    bus.m_ready = 1'b1;
    do_start(3, 1'b0);
    check("busy_after_start", bus.busy, 1);
    check("valid_lat1", bus.m_valid, 0);
    tick;
    check("valid_lat2", bus.m_valid, 0);
    tick;
    check("valid_lat3", bus.m_valid, 1);
    collect(3, 1'b0, 0, -1, -1);

    // Bit-reversed N=8, started in the first IDLE cycle.
    do_start(3, 1'b1);
    collect(3, 1'b1, 0, -1, -1);

    // Full 4096-word bit-reversed frame under random backpressure.
    do_start(12, 1'b1);
    collect(12, 1'b1, 1, -1, -1);

    // Mid-frame start is ignored.
    do_start(4, 1'b1);
    collect(4, 1'b1, 0, 3, -1);

    // log2n clamping: 0 and 13 both mean 12; 1 is the smallest frame.
    do_start(0, 1'b0);
    collect(12, 1'b0, 0, -1, -1);
    do_start(13, 1'b1);
    collect(12, 1'b1, 0, -1, -1);
    do_start(1, 1'b1);
    collect(1, 1'b1, 0, -1, -1);

    // Reset mid-frame while stalled at beat 5.
    do_start(4, 1'b0);
    collect(4, 1'b0, 0, -1, 5);
    bus.m_ready = 1'b0;
    tick;
    check("pre_rst_index", bus.m_index, 5);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mrst_busy", bus.busy, 0);
    check("mrst_done", bus.done, 0);
    check("mrst_valid", bus.m_valid, 0);
    check("mrst_last", bus.m_last, 0);
    check("mrst_data", bus.m_data, 0);
    check("mrst_index", bus.m_index, 0);
    check("mrst_adr", bus.mem_read_adr, 0);
    tick;
    tick;
    check("mrst_stays_idle", bus.busy, 0);
    check("mrst_no_resume", bus.m_valid, 0);
    bus.m_ready = 1'b1;
    do_start(4, 1'b0);
    collect(4, 1'b0, 0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_bitrev_reader.md
# cache_bitrev_reader

Streaming read controller for the 4096 x 16 FFT sample cache. On `start` it walks one frame of N = 2^log2n words out of the cache, in natural or bit-reversed address order, and presents them on a valid/ready stream for the butterfly datapath. It drives the cache read address port and absorbs the cache's one-cycle registered read latency. A 2-entry output buffer provides full-rate throughput and lossless backpressure.

## Interface
- `ADDR_W`, 12: cache address width; maximum frame is 2^ADDR_W words.
- `DATA_W`, 16: sample width.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  single-cycle frame request; sampled only in IDLE.
- `log2n`  in  4  frame size exponent, latched on accepted `start`.
- `bitrev`  in  1  1 = bit-reversed order, 0 = linear order; latched on accepted `start`.
- `busy`  out  1  high from the cycle after an accepted `start` through the `done` cycle.
- `done`  out  1  one-cycle pulse after the last beat is accepted.
- `mem_read_adr`  out  ADDR_W  cache read address; combinational from the internal counter.
- `mem_read_data`  in  DATA_W  cache read data; valid one cycle after the address is sampled.
- `m_data`  out  DATA_W  stream data.
- `m_index`  out  ADDR_W  ordinal of the beat within the frame (0..N-1), not the cache address.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready.
- `m_last`  out  1  high with beat N-1.

## Operation
- States:
  - IDLE -> RUN on `start`.
  - RUN -> DRAIN after the issue with ordinal N-1.
  - DRAIN -> DONE when the FIFO is empty and nothing is in flight.
  - DONE -> IDLE unconditionally after one cycle; `done` = 1 in DONE.
- log2n latch: legal range 1..12. A value of 0 or above 12 is latched as 12.
- Issue counter `idx` (ADDR_W bits) runs 0..N-1.
  - `mem_read_adr` = `idx` when `bitrev` = 0.
  - `mem_read_adr` = reverse of `idx`[log2n-1:0] when `bitrev` = 1. Bits above log2n-1 are 0.
- Issue: in RUN, an issue occurs at an edge when count + inflight − pop < 2.
  - count = FIFO occupancy (0..2).
  - inflight = 1 if an issue occurred at the previous edge.
  - pop = `m_valid` & `m_ready`.
  - On issue, `idx` increments and the ordinal is recorded in the in-flight tag.
- Capture: when inflight = 1, {`mem_read_data`, tag, tag == N-1} is pushed into the 2-entry FIFO at the current edge.
  - The credit rule guarantees the FIFO never overflows.
- Output: `m_valid` = FIFO not empty. `m_data`, `m_index` and `m_last` come from the FIFO head and are held stable while `m_valid` & !`m_ready`.
- `start` is ignored outside IDLE, including in DONE.
- `rst` at any point, including mid-frame:
  - Next state is IDLE; FIFO, inflight and `idx` are cleared.
  - All outputs are 0: `busy`, `done`, `m_valid`, `m_last`, `m_data`, `m_index`, and `mem_read_adr` (`idx` = 0).
  - No partial frame resumes.

## Timing
- `start` sampled at edge E: `busy` = 1 after E; first issue at edge E+1; first capture at E+2; `m_valid` first high in the cycle after E+2.
- With `m_ready` held high: one beat per cycle, no bubbles, N consecutive beats.
- `done` is high in the cycle after the edge that accepts the `m_last` beat. `busy` falls after that cycle.
- Minimum frame-to-frame gap: `start` accepted in the first IDLE cycle after DONE.
- Backpressure: at most 2 beats buffered plus 1 in flight. When `m_ready` goes low, issue stops within one edge; no data is lost or duplicated.
- Simultaneous push and pop on a full FIFO cannot occur. Push and pop together at count 1 leaves the count at 1.

## Test plan
- Linear order, `m_ready` = 1:
  - Setup: cache preloaded MEM[i] = 0x1000+i; log2n = 3, `bitrev` = 0.
  - Expect: `m_data` 0x1000..0x1007 on consecutive cycles, `m_index` 0..7, `m_last` only on the 8th beat.
  - Expect: first `m_valid` 3 cycles after `start`; `done` pulse 1 cycle after the last beat.
- Bit-reversed order: same preload, log2n = 3, `bitrev` = 1.
  - Expect `m_data` 0x1000, 0x1004, 0x1002, 0x1006, 0x1001, 0x1005, 0x1003, 0x1007.
- Random backpressure over a full frame:
  - Setup: log2n = 12, `bitrev` = 1, `m_ready` toggled pseudo-randomly.
  - Expect exactly 4096 beats, `m_data` = MEM[rev12(k)] for beat k, and `m_data`/`m_index` stable while stalled.
- Ignored start and clamping:
  - A `start` pulse mid-frame is ignored; beat count stays N.
  - log2n = 0 produces 4096 beats; log2n = 1 produces 2 beats (0x1000, 0x1001) with `bitrev` = 1.
- Reset mid-frame:
  - Stimulus: `rst` pulsed at beat 5 of an N = 16 frame with `m_ready` low.
  - Expect: after the edge, all outputs are 0 and the state is IDLE.
  - Expect: a new `start` yields a clean frame beginning at `m_index` 0.
